// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: CH lanes share one period counter; each lane holds a
// double-buffered duty (shadow -> active) that is swapped only on a period boundary.

module pwm_multi_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_boundary,
  input  logic             i_wr_hit,
  input  logic [CNT_W-1:0] i_wr_duty,
  input  logic [CNT_W-1:0] i_cnt_nxt,
  output logic             o_pwm
);
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic             r_pwm;
  logic [CNT_W-1:0] w_shadow_fwd;

  // A write landing on the boundary edge belongs to the period that edge starts.
  assign w_shadow_fwd = i_wr_hit ? i_wr_duty : r_shadow;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr_hit)
        r_shadow <= i_wr_duty;
      if (!i_en)
        r_pwm <= 1'b0;
      else if (i_boundary) begin
        r_active <= w_shadow_fwd;
        r_pwm    <= (w_shadow_fwd != '0);
      end else
        r_pwm <= (i_cnt_nxt < r_active);
    end
  end

  assign o_pwm = r_pwm;
endmodule

module pwm_multi #(
  parameter int CH     = 4,
  parameter int CNT_W  = 8,
  parameter int PERIOD = 100,
  parameter int CH_W   = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_valid,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  output logic [CH-1:0]    pwm_out,
  output logic             period_tick
);
  localparam logic [CNT_W-1:0] LP_PERIOD = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(PERIOD - 1);

  if (PERIOD < 2 || PERIOD > (2**CNT_W) - 1 || (2**CH_W) < CH) begin : g_bad_params
    $error("pwm_multi: illegal parameter combination");
  end

  typedef struct packed {
    logic             vld;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] duty;
  } wr_req_t;

  wr_req_t          w_wr_req;
  logic [CH-1:0]    w_wr_hit;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_boundary;
  logic [CNT_W-1:0] r_cnt;
  logic             r_running;
  logic             r_tick;

  // Requests above PERIOD saturate to "always high".
  assign w_wr_req.vld  = wr_valid;
  assign w_wr_req.ch   = wr_ch;
  assign w_wr_req.duty = (wr_duty > LP_PERIOD) ? LP_PERIOD : wr_duty;

  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_boundary = !r_running || (r_cnt == LP_LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!en) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_boundary) begin
      r_cnt     <= '0;
      r_running <= 1'b1;
      r_tick    <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_tick    <= 1'b0;
    end
  end

  // Channel indices >= CH never match any lane, so such writes are dropped.
  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    assign w_wr_hit[gi] = w_wr_req.vld && (w_wr_req.ch == CH_W'(gi));

    pwm_multi_lane #(.CNT_W(CNT_W)) u_lane (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .i_en       (en),
      .i_boundary (w_boundary),
      .i_wr_hit   (w_wr_hit[gi]),
      .i_wr_duty  (w_wr_req.duty),
      .i_cnt_nxt  (w_cnt_nxt),
      .o_pwm      (pwm_out[gi])
    );
  end

  assign period_tick = r_tick;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: table of whole periods (writes + expected high times)
// followed by hand-written enable-gap and mid-period reset sequences.

module tb_pwm_multi;
  localparam int CH = 4, CNT_W = 8, PERIOD = 100, CH_W = 3;

  logic             clk_in = 1'b0;
  logic             rst_n, en, wr_valid;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_duty;
  logic [CH-1:0]    pwm_out;
  logic             period_tick;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_multi #(.CH(CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .CH_W(CH_W)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .wr_valid    (wr_valid),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic            v;
    logic [CH_W-1:0] ch;
    logic [7:0]      duty;
    logic [7:0]      at;     // edge index within the period; 0 is the boundary edge
  } wr_t;

  typedef struct packed {
    wr_t [3:0]       w;
    logic [3:0][7:0] exp;    // expected high cycles per channel in this period
  } vec_t;

  vec_t tbl[9];

  function automatic wr_t mk_wr(input int ch, input int duty, input int at);
    wr_t r;
    r.v = 1'b1; r.ch = CH_W'(ch); r.duty = 8'(duty); r.at = 8'(at);
    return r;
  endfunction

  function automatic vec_t mk_vec(input int e0, input int e1, input int e2, input int e3);
    vec_t r;
    r = '0;
    r.exp[0] = 8'(e0); r.exp[1] = 8'(e1); r.exp[2] = 8'(e2); r.exp[3] = 8'(e3);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Runs PERIOD edges starting with the boundary edge; checks tick placement and
  // that each channel is high exactly for cycles 0..exp-1.
  task automatic run_period(input vec_t v, input string tag);
    int hi[4];
    int bad[4];
    int ticks;
    int tick0;
    ticks = 0; tick0 = 0;
    for (int c = 0; c < 4; c++) begin hi[c] = 0; bad[c] = 0; end
    for (int k = 0; k < PERIOD; k++) begin
      wr_valid = 1'b0;
      for (int s = 0; s < 4; s++)
        if (v.w[s].v && int'(v.w[s].at) == k) begin
          wr_valid = 1'b1; wr_ch = v.w[s].ch; wr_duty = v.w[s].duty;
        end
      step();
      wr_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (pwm_out[c]) hi[c]++;
        if (pwm_out[c] != (k < int'(v.exp[c]))) bad[c]++;
      end
      if (period_tick) ticks++;
      if (k == 0) tick0 = int'(period_tick);
    end
    chk($sformatf("%s tick_first_cycle", tag), tick0, 1);
    chk($sformatf("%s tick_count", tag), ticks, 1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s ch%0d high_cycles", tag, c), hi[c], int'(v.exp[c]));
      chk($sformatf("%s ch%0d shape_errors", tag, c), bad[c], 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_duty = '0;

    tbl[0] = mk_vec(0, 0, 0, 0);
    tbl[1] = mk_vec(0, 0, 0, 0);
    tbl[2] = mk_vec(0, 0, 0, 0);
    tbl[2].w[0] = mk_wr(0, 30, 10);  tbl[2].w[1] = mk_wr(1, 1, 20);
    tbl[2].w[2] = mk_wr(2, 99, 30);  tbl[2].w[3] = mk_wr(3, 100, 40);
    tbl[3] = mk_vec(30, 1, 99, 100);
    tbl[4] = mk_vec(30, 1, 99, 100);
    tbl[4].w[0] = mk_wr(1, 200, 50); tbl[4].w[1] = mk_wr(5, 7, 60);
    tbl[5] = mk_vec(30, 100, 99, 100);
    tbl[5].w[0] = mk_wr(0, 10, 5);   tbl[5].w[1] = mk_wr(0, 20, 70);
    tbl[6] = mk_vec(20, 100, 99, 100);
    tbl[7] = mk_vec(50, 100, 99, 100);
    tbl[7].w[0] = mk_wr(0, 50, 0);   tbl[7].w[1] = mk_wr(0, 60, 1);
    tbl[8] = mk_vec(60, 100, 99, 100);

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset%0d pwm_out", i), int'(pwm_out), 0);
      chk($sformatf("reset%0d period_tick", i), int'(period_tick), 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_period(tbl[i], $sformatf("P%0d", i));

    // Enable gap: load ch0=40, drop en at cnt=20, write ch1=25 while disabled.
    begin
      vec_t v;
      int gap_pwm, gap_tick;
      v = mk_vec(60, 100, 99, 100);
      v.w[0] = mk_wr(0, 40, 10);
      run_period(v, "P9");
      for (int k = 0; k <= 20; k++) step();
      chk("gap pre_drop pwm_out", int'(pwm_out), 15);
      en = 1'b0;
      gap_pwm = 0; gap_tick = 0;
      for (int k = 0; k < 5; k++) begin
        if (k == 2) begin wr_valid = 1'b1; wr_ch = 3'd1; wr_duty = 8'd25; end
        step();
        wr_valid = 1'b0;
        if (pwm_out != '0) gap_pwm++;
        if (period_tick) gap_tick++;
      end
      chk("gap nonzero_pwm_cycles", gap_pwm, 0);
      chk("gap tick_cycles", gap_tick, 0);
      en = 1'b1;
      run_period(mk_vec(40, 25, 99, 100), "reenable");

      // Mid-period reset at cnt=50 with every duty at 70.
      v = mk_vec(40, 25, 99, 100);
      v.w[0] = mk_wr(0, 70, 10); v.w[1] = mk_wr(1, 70, 20);
      v.w[2] = mk_wr(2, 70, 30); v.w[3] = mk_wr(3, 70, 40);
      run_period(v, "load70");
      for (int k = 0; k <= 50; k++) step();
      chk("midrst pre pwm_out", int'(pwm_out), 15);
      rst_n = 1'b0;
      step();
      chk("midrst pwm_out", int'(pwm_out), 0);
      chk("midrst period_tick", int'(period_tick), 0);
      rst_n = 1'b1;
      run_period(mk_vec(0, 0, 0, 0), "post_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
